// File: rtl/floating_point_adder.sv
// floating_point_adder: fully pipelined IEEE-754 binary32 adder with
// round-to-nearest-ties-to-even. Operands are captured on the edge where
// in_valid is sampled. Stage 1 unpacks, swaps and aligns. Stage 2 adds,
// normalizes, rounds and packs into the result register.
// Configuration macro FPADD_SUBNORMAL_EN: when defined, subnormals are fully
// supported (gradual underflow). When undefined, subnormal inputs and tiny
// results are flushed to signed zero.
module floating_point_adder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        out_valid
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Leading-zero count of a 27-bit vector (27 when the vector is zero)
  function automatic logic [4:0] clz27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd27;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(26 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  // Operand capture registers
  logic        v0_q, v0_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  // Stage 1 registers (aligned operands, special-case result)
  logic        v1_q, v1_d, spec1_q, spec1_d, sign1_q, sign1_d;
  logic        sub1_q, sub1_d, zsign1_q, zsign1_d;
  logic [31:0] sval1_q, sval1_d;
  logic [7:0]  exp1_q, exp1_d;
  logic [26:0] mb1_q, mb1_d, ms1_q, ms1_d;
  // Output registers
  logic [31:0] result_q, result_d;
  logic        out_valid_q, out_valid_d;

  // Stage 1 working signals
  logic [7:0]  ea, eb, eeff_a, eeff_b, e_small, diff;
  logic [23:0] ma, mb, m_big, m_small;
  logic [49:0] wide;
  logic        swap, nan_a, nan_b, inf_a, inf_b;

  // Stage 2 working signals
  logic [27:0] sum;
  logic [26:0] m;
  logic [9:0]  e, en, sh_w, ef;
  logic [4:0]  lz;
  logic        up, tiny;
  logic [24:0] mr;
  logic [22:0] frac;
  logic [31:0] packed_res;

  // Operand capture: sample a/b only when qualified
  always_comb begin
    v0_d = in_valid;
    a_d  = in_valid ? a : a_q;
    b_d  = in_valid ? b : b_q;
  end

  // Stage 1: unpack, classify specials, order by magnitude, align small operand
  always_comb begin
    ea    = a_q[30:23];
    eb    = b_q[30:23];
    nan_a = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
    nan_b = (eb == 8'hFF) && (b_q[22:0] != 23'd0);
    inf_a = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
    inf_b = (eb == 8'hFF) && (b_q[22:0] == 23'd0);
`ifdef FPADD_SUBNORMAL_EN
    eeff_a = (ea == 8'd0) ? 8'd1 : ea;
    eeff_b = (eb == 8'd0) ? 8'd1 : eb;
    ma     = {(ea != 8'd0), a_q[22:0]};
    mb     = {(eb != 8'd0), b_q[22:0]};
`else
    eeff_a = ea;
    eeff_b = eb;
    ma     = (ea == 8'd0) ? 24'd0 : {1'b1, a_q[22:0]};
    mb     = (eb == 8'd0) ? 24'd0 : {1'b1, b_q[22:0]};
`endif
    swap     = {eeff_b, mb} > {eeff_a, ma};
    exp1_d   = swap ? eeff_b : eeff_a;
    e_small  = swap ? eeff_a : eeff_b;
    m_big    = swap ? mb : ma;
    m_small  = swap ? ma : mb;
    sign1_d  = swap ? b_q[31] : a_q[31];
    sub1_d   = a_q[31] ^ b_q[31];
    zsign1_d = a_q[31] & b_q[31];
    diff     = exp1_d - e_small;
    wide     = {m_small, 26'd0} >> diff;
    mb1_d    = {m_big, 3'b000};
    // Shifts of 26 or more leave the small operand only as a sticky bit
    ms1_d    = (diff >= 8'd26) ? {26'd0, |m_small} : {wide[49:24], |wide[23:0]};
    v1_d     = v0_q;
    if (nan_a || nan_b) begin
      spec1_d = 1'b1;
      sval1_d = QNAN;
    end else if (inf_a && inf_b) begin
      spec1_d = 1'b1;
      sval1_d = (a_q[31] != b_q[31]) ? QNAN : {a_q[31], 8'hFF, 23'd0};
    end else if (inf_a) begin
      spec1_d = 1'b1;
      sval1_d = {a_q[31], 8'hFF, 23'd0};
    end else if (inf_b) begin
      spec1_d = 1'b1;
      sval1_d = {b_q[31], 8'hFF, 23'd0};
    end else begin
      spec1_d = 1'b0;
      sval1_d = 32'd0;
    end
  end

  // Stage 2: add/subtract, normalize, round to nearest even, pack
  always_comb begin
    sum  = sub1_q ? ({1'b0, mb1_q} - {1'b0, ms1_q}) : ({1'b0, mb1_q} + {1'b0, ms1_q});
    e    = {2'b00, exp1_q};
    lz   = clz27(sum[26:0]);
    sh_w = 10'd0;
    tiny = 1'b0;
    if (sum[27]) begin
      m  = {sum[27:2], sum[1] | sum[0]};
      en = e + 10'd1;
    end else begin
`ifdef FPADD_SUBNORMAL_EN
      // Never normalize below exponent 1; what remains is a subnormal
      sh_w = ({5'd0, lz} < (e - 10'd1)) ? {5'd0, lz} : (e - 10'd1);
`else
      sh_w = {5'd0, lz};
      tiny = (sh_w >= e);
`endif
      m  = sum[26:0] << sh_w;
      en = e - sh_w;
    end
    up = m[2] & (m[3] | m[1] | m[0]);
    mr = {1'b0, m[26:3]} + {24'd0, up};
    if (mr[24]) begin
      ef   = en + 10'd1;
      frac = mr[23:1];
    end else begin
      ef   = mr[23] ? en : 10'd0;
      frac = mr[22:0];
    end
    if (spec1_q) begin
      packed_res = sval1_q;
    end else if (sum == 28'd0) begin
      packed_res = {zsign1_q, 31'd0};
    end else if (tiny) begin
      packed_res = {sign1_q, 31'd0};
    end else if (ef >= 10'd255) begin
      packed_res = {sign1_q, 8'hFF, 23'd0};
    end else begin
      packed_res = {sign1_q, ef[7:0], frac};
    end
    out_valid_d = v1_q;
    result_d    = v1_q ? packed_res : result_q;
  end

  // Pipeline registers with synchronous reset clearing data and valid bits
  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q        <= 1'b0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      v1_q        <= 1'b0;
      spec1_q     <= 1'b0;
      sval1_q     <= 32'd0;
      sign1_q     <= 1'b0;
      sub1_q      <= 1'b0;
      zsign1_q    <= 1'b0;
      exp1_q      <= 8'd0;
      mb1_q       <= 27'd0;
      ms1_q       <= 27'd0;
      result_q    <= 32'd0;
      out_valid_q <= 1'b0;
    end else begin
      v0_q        <= v0_d;
      a_q         <= a_d;
      b_q         <= b_d;
      v1_q        <= v1_d;
      spec1_q     <= spec1_d;
      sval1_q     <= sval1_d;
      sign1_q     <= sign1_d;
      sub1_q      <= sub1_d;
      zsign1_q    <= zsign1_d;
      exp1_q      <= exp1_d;
      mb1_q       <= mb1_d;
      ms1_q       <= ms1_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_floating_point_adder.sv
// Scoreboard bench for floating_point_adder: directed vectors with constant
// expectations, then random vectors checked against a real-arithmetic model.
module tb_floating_point_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [31:0] result;
  logic        out_valid;

  floating_point_adder dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .result   (result),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

`ifdef FPADD_SUBNORMAL_EN
  localparam logic [31:0] SUB_SUM = 32'h0000_0002;
`else
  localparam logic [31:0] SUB_SUM = 32'h0000_0000;
`endif

  // {a, b, expected}
  localparam logic [95:0] DIR [0:15] = '{
    {32'h40A00000, 32'h40400000, 32'h41000000},
    {32'h3F800000, 32'hBF800000, 32'h00000000},
    {32'h7F800000, 32'hFF800000, 32'h7FC00000},
    {32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000},
    {32'h3F800000, 32'h33800000, 32'h3F800000},
    {32'h3F800001, 32'h33800000, 32'h3F800002},
    {32'h00000001, 32'h00000001, SUB_SUM},
    {32'h7F800001, 32'h3F800000, 32'h7FC00000},
    {32'h7F800000, 32'h3F800000, 32'h7F800000},
    {32'hFF800000, 32'h7F7FFFFF, 32'hFF800000},
    {32'h80000000, 32'h80000000, 32'h80000000},
    {32'h00000000, 32'h80000000, 32'h00000000},
    {32'h3FFFFFFF, 32'h33800000, 32'h40000000},
    {32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF800000},
    {32'h40000000, 32'hC0400000, 32'hBF800000},
    {32'h3F800001, 32'hBF800000, 32'h34000000}
  };

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s got=%08h expected=%08h (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  function automatic real f2r(input logic [31:0] x);
    real v;
    int  e;
    int  fi;
    e  = int'(x[30:23]);
    fi = int'(x[22:0]);
    if (e == 0) v = fi * (2.0 ** (-149.0));
    else        v = (8388608.0 + fi) * (2.0 ** real'(e - 150));
    return x[31] ? -v : v;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic        s;
    real         mag;
    logic [63:0] bits;
    int          fe;
    logic [52:0] mant;
    logic [23:0] keep;
    logic [28:0] rem;
    logic [24:0] k;
    logic        rup;
    s   = (r < 0.0);
    mag = s ? -r : r;
    if (mag < (2.0 ** (-126.0))) begin
`ifdef FPADD_SUBNORMAL_EN
      return {s, 8'd0, 23'($rtoi(mag * (2.0 ** 149.0)))};
`else
      return {s, 31'd0};
`endif
    end
    bits = $realtobits(mag);
    fe   = int'(bits[62:52]) - 896;
    mant = {1'b1, bits[51:0]};
    keep = mant[52:29];
    rem  = mant[28:0];
    rup  = (rem > 29'h1000_0000) || ((rem == 29'h1000_0000) && keep[0]);
    k    = {1'b0, keep} + {24'd0, rup};
    if (k[24]) begin
      fe++;
      k = k >> 1;
    end
    if (fe >= 255) return {s, 8'hFF, 23'd0};
    return {s, 8'(fe), k[22:0]};
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] xa, yb;
    real         r;
    xa = x;
    yb = y;
`ifndef FPADD_SUBNORMAL_EN
    if (xa[30:23] == 8'd0) xa[22:0] = 23'd0;
    if (yb[30:23] == 8'd0) yb[22:0] = 23'd0;
`endif
    if ((xa[30:23] == 8'hFF && xa[22:0] != 23'd0) || (yb[30:23] == 8'hFF && yb[22:0] != 23'd0))
      return 32'h7FC00000;
    if (xa[30:23] == 8'hFF && yb[30:23] == 8'hFF)
      return (xa[31] != yb[31]) ? 32'h7FC00000 : xa;
    if (xa[30:23] == 8'hFF) return xa;
    if (yb[30:23] == 8'hFF) return yb;
    if (xa[30:0] == 31'd0 && yb[30:0] == 31'd0) return {xa[31] & yb[31], 31'd0};
    r = f2r(xa) + f2r(yb);
    if (r == 0.0) return 32'd0;
    return r2f(r);
  endfunction

  task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic [31:0] expv);
    exp_t t;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a        = x;
    b        = y;
    t.r      = expv;
    t.due    = cyc + 3;
    sb_q.push_back(t);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
  endtask

  // Cycle counter advancing on every active edge
  always @(posedge clk) cyc++;

  // Output monitor: pop and compare on every out_valid, flag late or spurious outputs
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        chk("spurious_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("result", result, mon_e.r);
        chk("latency", 32'(cyc), 32'(mon_e.due));
      end
    end
    if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
      chk("missing_valid", 32'd0, 32'd1);
      void'(sb_q.pop_front());
    end
  end

  initial begin
    logic [31:0] x, y;
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_result", result, 32'd0);
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed vectors back-to-back
    for (int i = 0; i < 16; i++) drive(DIR[i][95:64], DIR[i][63:32], DIR[i][31:0]);
    repeat (4) idle();

    // Random vectors with occasional bubbles
    for (int i = 0; i < 80; i++) begin
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 1) == 1) y[30:23] = x[30:23] + 8'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) idle();
      drive(x, y, ref_add(x, y));
    end

    // Four back-to-back then reset mid-stream with in_valid held high
    for (int i = 0; i < 4; i++) begin
      x = $urandom;
      y = $urandom;
      drive(x, y, ref_add(x, y));
    end
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 32'h40A00000;
    b        = 32'h40400000;
    while (sb_q.size() > 0 && sb_q[$].due > cyc) void'(sb_q.pop_back());
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("midreset_result", result, 32'd0);
      chk("midreset_valid", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    repeat (4) idle();

    // First operands after reset plus a few more
    drive(32'h40A00000, 32'h40400000, 32'h41000000);
    for (int i = 0; i < 6; i++) begin
      x = $urandom;
      y = $urandom;
      drive(x, y, ref_add(x, y));
    end
    repeat (6) idle();
    chk("drain_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
